ysyx_mem_resp: RTL and testbench

- Memory responder on the other end of the EXU's load/store request interface.
- Accepts one read or write request at a time through a valid/ready handshake.
- Services each request from an internal word array after a programmable latency, then returns a response through a second valid/ready handshake.
- Replaces the combinational pmem_read/pmem_write path with a cycle-accurate, stallable memory model.

---
 rtl/ysyx_mem_resp.sv | 176 +++++++++++++++++
 tb/tb_ysyx_mem_resp.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_mem_resp.sv
// ysyx_mem_resp: word-array memory model behind the EXU load/store port.
// One request at a time, LATENCY wait cycles, then a held response.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake
//   req_wen/addr/wdata/wmask request fields, sampled at acceptance only
//   resp_valid/resp_ready    response handshake
//   resp_rdata/resp_err      read data, out-of-range flag
module ysyx_mem_resp #(
    parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wmask,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0] CNT_INIT =
        (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e state_q, state_d;

    logic [3:0]       cnt_q, cnt_d;
    logic             wen_q, wen_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       wmask_q, wmask_d;
    logic             oor_q, oor_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;

    logic [31:0] mem [DEPTH_WORDS];

    // Request decode, valid only at the accepting edge.
    logic [31:0]      in_off;
    logic             in_oor;
    logic [IDX_W-1:0] in_idx;

    // Access port: either the live request (LATENCY=0) or the latched one.
    logic             acc;
    logic             acc_wen;
    logic [IDX_W-1:0] acc_idx;
    logic [31:0]      acc_wdata;
    logic [3:0]       acc_wmask;
    logic             acc_oor;
    logic             mem_we;

    assign in_off = req_addr - ADDR_BASE;
    assign in_oor = (req_addr < ADDR_BASE) || ({1'b0, in_off} >= SPAN);
    assign in_idx = in_off[IDX_W+1:2];

    assign req_ready  = (state_q == S_IDLE) && !rst;
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wen_d     = wen_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        wmask_d   = wmask_q;
        oor_d     = oor_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        acc       = 1'b0;
        acc_wen   = wen_q;
        acc_idx   = idx_q;
        acc_wdata = wdata_q;
        acc_wmask = wmask_q;
        acc_oor   = oor_q;
        mem_we    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    wen_d   = req_wen;
                    idx_d   = in_idx;
                    wdata_d = req_wdata;
                    wmask_d = req_wmask;
                    oor_d   = in_oor;
                    if (LATENCY == 0) begin
                        acc       = 1'b1;
                        acc_wen   = req_wen;
                        acc_idx   = in_idx;
                        acc_wdata = req_wdata;
                        acc_wmask = req_wmask;
                        acc_oor   = in_oor;
                        state_d   = S_RESP;
                    end else begin
                        cnt_d   = CNT_INIT;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    acc     = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    rdata_d = 32'h0;
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (acc) begin
            // A reset edge cancels the pending write along with the request.
            mem_we  = acc_wen && !acc_oor && !rst;
            rdata_d = (acc_wen || acc_oor) ? 32'h0 : mem[acc_idx];
            err_d   = acc_oor;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            wen_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 32'h0;
            wmask_q <= 4'h0;
            oor_q   <= 1'b0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wen_q   <= wen_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            oor_q   <= oor_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Array is not reset; byte lanes follow the write mask.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_wmask[i]) begin
                    mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ysyx_mem_resp.sv
// Bench for ysyx_mem_resp: LATENCY=2 and LATENCY=0 instances,
// directed vector table plus reset/stall/back-to-back sequences.
module tb_ysyx_mem_resp;

    logic        clk = 1'b0;
    logic        rst;

    logic        req_valid, req_ready, req_wen;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wmask;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;

    logic        z_req_valid, z_req_ready, z_req_wen;
    logic [31:0] z_req_addr, z_req_wdata;
    logic [3:0]  z_req_wmask;
    logic        z_resp_valid, z_resp_ready, z_resp_err;
    logic [31:0] z_resp_rdata;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    ysyx_mem_resp #(.LATENCY(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wen    (req_wen),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wmask  (req_wmask),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    ysyx_mem_resp #(.LATENCY(0)) dut0 (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (z_req_valid),
        .req_ready  (z_req_ready),
        .req_wen    (z_req_wen),
        .req_addr   (z_req_addr),
        .req_wdata  (z_req_wdata),
        .req_wmask  (z_req_wmask),
        .resp_valid (z_resp_valid),
        .resp_ready (z_resp_ready),
        .resp_rdata (z_resp_rdata),
        .resp_err   (z_resp_err)
    );

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    // Counts negedges after the accepting edge until resp_valid.
    task automatic wait_valid(output int n);
        n = 0;
        @(negedge clk);
        while (!resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic do_req(input string nm, input vec_t v);
        int n;
        @(negedge clk);
        req_wen    = v.wen;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        req_wmask  = v.wmask;
        req_valid  = 1'b1;
        resp_ready = 1'b0;
        chk({nm, "_ready"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = 32'h8000_0000;
        req_wdata = 32'h5A5A_5A5A;
        req_wmask = 4'hF;
        req_wen   = ~v.wen;
        wait_valid(n);
        chk({nm, "_lat"}, 32'(n), 32'd2);
        chk({nm, "_rdata"}, resp_rdata, v.exp_rdata);
        chk({nm, "_err"}, 32'(resp_err), 32'(v.exp_err));
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        chk({nm, "_idle"}, {30'd0, resp_valid, req_ready}, 32'd1);
    endtask

    vec_t vt [12];
    vec_t z_ops [6];

    initial begin
        #200000;
        $display("FAIL watchdog: no finish");
        $fatal(1);
    end

    initial begin
        int n;
        vt[0]  = '{1'b1, 32'h8000_0000, 32'hA5A5_0001, 4'hF, 32'h0, 1'b0};
        vt[1]  = '{1'b1, 32'h8000_0FFC, 32'h0BAD_F00D, 4'hF, 32'h0, 1'b0};
        vt[2]  = '{1'b1, 32'h7FFF_FFFC, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1};
        vt[3]  = '{1'b0, 32'h8000_1000, 32'h0, 4'h0, 32'h0, 1'b1};
        vt[4]  = '{1'b0, 32'h8000_0000, 32'h0, 4'h0, 32'hA5A5_0001, 1'b0};
        vt[5]  = '{1'b0, 32'h8000_0FFF, 32'h0, 4'h0, 32'h0BAD_F00D, 1'b0};
        vt[6]  = '{1'b1, 32'h8000_0010, 32'h1122_3344, 4'b0101, 32'h0, 1'b0};
        vt[7]  = '{1'b0, 32'h8000_0010, 32'h0, 4'h0, 32'hDE22_BE44, 1'b0};
        vt[8]  = '{1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0};
        vt[9]  = '{1'b0, 32'h8000_0012, 32'h0, 4'h0, 32'hDE22_BE44, 1'b0};
        vt[10] = '{1'b1, 32'h8000_0FFC, 32'h7700_0000, 4'b1000, 32'h0, 1'b0};
        vt[11] = '{1'b0, 32'h8000_0FFC, 32'h0, 4'h0, 32'h77AD_F00D, 1'b0};

        z_ops[0] = '{1'b1, 32'h8000_0000, 32'h0000_0100, 4'hF, 32'h0, 1'b0};
        z_ops[1] = '{1'b1, 32'h8000_0004, 32'h0000_0104, 4'hF, 32'h0, 1'b0};
        z_ops[2] = '{1'b1, 32'h8000_0008, 32'h0000_0108, 4'hF, 32'h0, 1'b0};
        z_ops[3] = '{1'b0, 32'h8000_0000, 32'h0, 4'h0, 32'h0000_0100, 1'b0};
        z_ops[4] = '{1'b0, 32'h8000_0004, 32'h0, 4'h0, 32'h0000_0104, 1'b0};
        z_ops[5] = '{1'b0, 32'h8000_0008, 32'h0, 4'h0, 32'h0000_0108, 1'b0};

        rst = 1'b1;
        req_valid = 1'b0; req_wen = 1'b0; req_addr = 32'h0;
        req_wdata = 32'h0; req_wmask = 4'h0; resp_ready = 1'b0;
        z_req_valid = 1'b0; z_req_wen = 1'b0; z_req_addr = 32'h0;
        z_req_wdata = 32'h0; z_req_wmask = 4'h0; z_resp_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_outs", {resp_rdata[30:0], resp_valid},
            32'd0);
        chk("rst_err", 32'(resp_err), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_release_ready", 32'(req_ready), 32'd1);

        // Reset during RESP: write already done on entry to RESP
        @(negedge clk);
        req_wen = 1'b1; req_addr = 32'h8000_0010;
        req_wdata = 32'hDEAD_BEEF; req_wmask = 4'hF; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        wait_valid(n);
        chk("rr_lat", 32'(n), 32'd2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rr_cleared", {resp_rdata[30:0], resp_valid}, 32'd0);
        chk("rr_err", 32'(resp_err), 32'd0);
        chk("rr_ready_in_rst", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rr_ready_after", 32'(req_ready), 32'd1);

        // Stalled read: six valid cycles, data held
        @(negedge clk);
        req_wen = 1'b0; req_addr = 32'h8000_0010; req_valid = 1'b1;
        resp_ready = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr = 32'h8000_0000;
        wait_valid(n);
        chk("st_lat", 32'(n), 32'd2);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("st_valid%0d", i), 32'(resp_valid), 32'd1);
            chk($sformatf("st_rdata%0d", i), resp_rdata, 32'hDEAD_BEEF);
            chk($sformatf("st_noready%0d", i), 32'(req_ready), 32'd0);
            if (i == 5) resp_ready = 1'b1;
            else @(negedge clk);
        end
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        chk("st_idle", {30'd0, resp_valid, req_ready}, 32'd1);

        // Vector table on the LATENCY=2 instance
        for (int i = 0; i < 12; i++) begin
            do_req($sformatf("vec%0d", i), vt[i]);
        end

        // LATENCY=0 back-to-back with req_valid held high
        @(negedge clk);
        z_req_valid = 1'b1;
        z_req_wen   = z_ops[0].wen;
        z_req_addr  = z_ops[0].addr;
        z_req_wdata = z_ops[0].wdata;
        z_req_wmask = z_ops[0].wmask;
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("z%0d_ready", k),
                {30'd0, z_resp_valid, z_req_ready}, 32'd1);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("z%0d_valid", k),
                {30'd0, z_resp_valid, z_req_ready}, 32'd2);
            chk($sformatf("z%0d_rdata", k), z_resp_rdata, z_ops[k].exp_rdata);
            chk($sformatf("z%0d_err", k), 32'(z_resp_err), 32'd0);
            if (k < 5) begin
                z_req_wen   = z_ops[k+1].wen;
                z_req_addr  = z_ops[k+1].addr;
                z_req_wdata = z_ops[k+1].wdata;
                z_req_wmask = z_ops[k+1].wmask;
            end else begin
                z_req_valid = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
        end
        chk("z_end_idle", {30'd0, z_resp_valid, z_req_ready}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
